// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and defaults for the PC fetch controller
package pc_pkg;

    localparam int PC_W_DEF       = 10;
    localparam int IDX_W_DEF      = 4;
    localparam int CNT_W_DEF      = 16;
    localparam int START_ADDR_DEF = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEQ  = 2'd0,
        ABS  = 2'd1,
        REL  = 2'd2,
        HOLD = 2'd3
    } sel_t;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - fetch control bus between sequencer, lookup table and ROM
interface pc_fetch_ctrl_if #(
    parameter int PC_W  = 10,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
);
    logic             Start;
    logic             Stall;
    logic             Halt;
    logic             BranchEn;
    logic             BranchRel;
    logic [IDX_W-1:0] BrIdx;
    logic [IDX_W-1:0] LutIdx;
    logic [PC_W-1:0]  Target;
    logic [PC_W-1:0]  ProgCtr;
    logic             Done;
    logic             Running;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        output Start, Stall, Halt, BranchEn, BranchRel, BrIdx, Target,
        input  LutIdx, ProgCtr, Done, Running, InstrCount
    );

    modport slave (
        input  Start, Stall, Halt, BranchEn, BranchRel, BrIdx, Target,
        output LutIdx, ProgCtr, Done, Running, InstrCount
    );
endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC mux and adder
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] target,
    input  sel_t            sel,
    output logic [PC_W-1:0] next_pc
);

    // Relative targets are two's complement, so a plain modulo-2^PC_W add covers negative offsets
    always_comb begin
        next_pc = pc;
        case (sel)
            SEQ:     next_pc = pc + PC_W'(1);
            ABS:     next_pc = target;
            REL:     next_pc = pc + target;
            default: next_pc = pc;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter and fetch sequencing (start, stall, branch, halt)
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int              PC_W       = PC_W_DEF,
    parameter int              IDX_W      = IDX_W_DEF,
    parameter logic [PC_W-1:0] START_ADDR = PC_W'(START_ADDR_DEF),
    parameter int              CNT_W      = CNT_W_DEF
) (
    input  logic           Clk,
    input  logic           Reset,
    pc_fetch_ctrl_if.slave bus
);

    state_t           state;
    sel_t             sel;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  next_pc;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             running_q;

    // Branch index goes straight to the lookup table; Target comes back the same cycle
    assign bus.LutIdx     = bus.BrIdx;
    assign bus.ProgCtr    = pc_q;
    assign bus.InstrCount = cnt_q;
    assign bus.Done       = done_q;
    assign bus.Running    = running_q;

    // Choose the next-PC source; stall and halt both freeze the PC, and only RUN advances it
    always_comb begin
        sel = HOLD;
        if (state == RUN && !bus.Stall && !bus.Halt) begin
            if (bus.BranchEn)
                sel = bus.BranchRel ? REL : ABS;
            else
                sel = SEQ;
        end
    end

    pc_next_sel #(.PC_W(PC_W)) u_next_sel (
        .pc      (pc_q),
        .target  (bus.Target),
        .sel     (sel),
        .next_pc (next_pc)
    );

    // Sequencer FSM: PC, retired count, Done and Running are all registered here
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            pc_q      <= START_ADDR;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state     <= RUN;
                        pc_q      <= START_ADDR;
                        cnt_q     <= '0;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.Stall) begin
                        pc_q <= next_pc;
                        if (cnt_q != {CNT_W{1'b1}})
                            cnt_q <= cnt_q + CNT_W'(1);
                        if (bus.Halt) begin
                            state     <= HALTED;
                            done_q    <= 1'b1;
                            running_q <= 1'b0;
                        end
                    end
                end
                HALTED: begin
                    if (bus.Start) begin
                        state     <= RUN;
                        pc_q      <= START_ADDR;
                        cnt_q     <= '0;
                        done_q    <= 1'b0;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
